// File: rtl/prog_ctr_if.sv
// Bus between the sequencing stage and the core/testbench: run/halt
// handshake, decoded control-transfer inputs and the PC/status outputs.
interface prog_ctr_if #(
  parameter int PW = 10,
  parameter int OW = 8,
  parameter int CW = 16
);
  logic          start;
  logic [PW-1:0] start_addr;
  logic          halt;
  logic          jump;
  logic          branch;
  logic          zero;
  logic [OW-1:0] offset;
  logic [PW-1:0] prog_ctr;
  logic          running;
  logic          ack;
  logic [CW-1:0] inst_cnt;

  // Handshake: start is a level request; while high the core is held at
  // start_addr. After start drops the core runs until a halt retires, then
  // ack stays high (running low) until the next start.
  modport master (
    output start, start_addr, halt, jump, branch, zero, offset,
    input  prog_ctr, running, ack, inst_cnt
  );

  modport slave (
    input  start, start_addr, halt, jump, branch, zero, offset,
    output prog_ctr, running, ack, inst_cnt
  );
endinterface

// File: rtl/prog_ctr.sv
// Program counter and sequencing stage: resolves jumps and zero-flag
// branches in the same cycle, owns the IDLE/RUN/DONE handshake and keeps a
// saturating retired-instruction counter.
module prog_ctr #(
  parameter int PW = 10,
  parameter int OW = 8,
  parameter int CW = 16
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  prog_ctr_if.slave  bus,
  output logic [1:0] dbg_state_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] pc_q, pc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          running_q, ack_q;
  logic          taken;
  logic [PW-1:0] offset_ext;

  assign offset_ext = {{(PW-OW){bus.offset[OW-1]}}, bus.offset};
  assign taken      = bus.jump | (bus.branch & bus.zero);

  // Next-state, next-PC and counter update; start overrides everything.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    if (bus.start) begin
      state_d = ST_IDLE;
      pc_d    = bus.start_addr;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_RUN;
        ST_RUN: begin
          cnt_d = (cnt_q == {CW{1'b1}}) ? cnt_q : cnt_q + CW'(1);
          if (bus.halt) begin
            state_d = ST_DONE;
          end else if (taken) begin
            pc_d = pc_q + offset_ext;
          end else begin
            pc_d = pc_q + PW'(1);
          end
        end
        ST_DONE: state_d = ST_DONE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State registers; running/ack are registered decodes of the next state
  // so they only change on a clock edge or reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      pc_q      <= '0;
      cnt_q     <= '0;
      running_q <= 1'b0;
      ack_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      cnt_q     <= cnt_d;
      running_q <= (state_d == ST_RUN);
      ack_q     <= (state_d == ST_DONE);
    end
  end

  assign bus.prog_ctr = pc_q;
  assign bus.running  = running_q;
  assign bus.ack      = ack_q;
  assign bus.inst_cnt = cnt_q;
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_prog_ctr.sv
// Directed bench for prog_ctr: reset, start latency, branches, jumps,
// wrap-around, halt/ack, restart, async reset and counter saturation.
module tb_prog_ctr;

  logic       clk;
  logic       rst_n;
  logic [1:0] dbg_state;
  logic [1:0] dbg_state_s;
  int         tests_run;
  int         tests_failed;

  prog_ctr_if #(.PW(10), .OW(8), .CW(16)) bus ();
  prog_ctr_if #(.PW(10), .OW(8), .CW(4))  bus_s ();

  prog_ctr #(.PW(10), .OW(8), .CW(16)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .bus         (bus.slave),
    .dbg_state_o (dbg_state)
  );

  prog_ctr #(.PW(10), .OW(8), .CW(4)) dut_sat (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .bus         (bus_s.slave),
    .dbg_state_o (dbg_state_s)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_main(input string tag, input logic [9:0] pc, input logic run,
                            input logic ack, input logic [15:0] cnt);
    check({tag, ".pc"},  32'(bus.prog_ctr), 32'(pc));
    check({tag, ".run"}, 32'(bus.running),  32'(run));
    check({tag, ".ack"}, 32'(bus.ack),      32'(ack));
    check({tag, ".cnt"}, 32'(bus.inst_cnt), 32'(cnt));
  endtask

  task automatic ctl(input logic h, input logic j, input logic b, input logic z,
                     input logic [7:0] off);
    bus.halt   = h;
    bus.jump   = j;
    bus.branch = b;
    bus.zero   = z;
    bus.offset = off;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n        = 1'b1;
    bus.start    = 1'b0;
    bus.start_addr = '0;
    ctl(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    bus_s.start      = 1'b1;
    bus_s.start_addr = '0;
    bus_s.halt       = 1'b0;
    bus_s.jump       = 1'b0;
    bus_s.branch     = 1'b0;
    bus_s.zero       = 1'b0;
    bus_s.offset     = '0;

    // reset
    #1 rst_n = 1'b0;
    #2;
    check_main("reset", 10'h000, 1'b0, 1'b0, 16'd0);
    check("reset.state", 32'(dbg_state), 32'd0);
    tick();
    tick();
    check_main("reset_hold", 10'h000, 1'b0, 1'b0, 16'd0);

    // start held two cycles, then released
    rst_n          = 1'b1;
    bus.start      = 1'b1;
    bus.start_addr = 10'h040;
    tick();
    tick();
    check_main("start_held", 10'h040, 1'b0, 1'b0, 16'd0);
    bus.start = 1'b0;
    tick();
    check_main("run_entry", 10'h040, 1'b1, 1'b0, 16'd0);
    check("run_entry.state", 32'(dbg_state), 32'd1);
    tick();
    check_main("seq1", 10'h041, 1'b1, 1'b0, 16'd1);
    tick();
    check_main("seq2", 10'h042, 1'b1, 1'b0, 16'd2);
    for (int i = 0; i < 5; i++) tick();
    check_main("seq7", 10'h047, 1'b1, 1'b0, 16'd7);

    // halt and frozen DONE state
    ctl(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    tick();
    check_main("halt", 10'h047, 1'b0, 1'b1, 16'd8);
    check("halt.state", 32'(dbg_state), 32'd2);
    for (int i = 0; i < 20; i++) begin
      ctl(i[1], i[0], 1'b1, 1'b1, 8'h05);
      tick();
      check_main("done_hold", 10'h047, 1'b0, 1'b1, 16'd8);
    end

    // restart from DONE
    ctl(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    bus.start      = 1'b1;
    bus.start_addr = 10'h050;
    tick();
    check_main("restart", 10'h050, 1'b0, 1'b0, 16'd0);
    check("restart.state", 32'(dbg_state), 32'd0);
    bus.start = 1'b0;
    tick();
    check_main("restart_run", 10'h050, 1'b1, 1'b0, 16'd0);

    // conditional branch taken / not taken, both flags, zero offset
    ctl(1'b0, 1'b0, 1'b1, 1'b1, 8'hFC);
    tick();
    check_main("br_taken", 10'h04C, 1'b1, 1'b0, 16'd1);
    ctl(1'b0, 1'b1, 1'b0, 1'b0, 8'h04);
    tick();
    check_main("jmp_fwd", 10'h050, 1'b1, 1'b0, 16'd2);
    ctl(1'b0, 1'b0, 1'b1, 1'b0, 8'hFC);
    tick();
    check_main("br_not_taken", 10'h051, 1'b1, 1'b0, 16'd3);
    ctl(1'b0, 1'b1, 1'b1, 1'b0, 8'h02);
    tick();
    check_main("jmp_and_br", 10'h053, 1'b1, 1'b0, 16'd4);
    ctl(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    tick();
    check_main("self_loop", 10'h053, 1'b1, 1'b0, 16'd5);

    // restart mid-RUN: in-flight instruction not counted
    ctl(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    bus.start      = 1'b1;
    bus.start_addr = 10'h3FE;
    tick();
    check_main("restart_mid_run", 10'h3FE, 1'b0, 1'b0, 16'd0);
    bus.start = 1'b0;
    tick();
    check_main("run_3fe", 10'h3FE, 1'b1, 1'b0, 16'd0);
    ctl(1'b0, 1'b1, 1'b0, 1'b0, 8'h05);
    tick();
    check_main("jmp_wrap", 10'h003, 1'b1, 1'b0, 16'd1);

    // increment wrap at the top of memory
    ctl(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    bus.start      = 1'b1;
    bus.start_addr = 10'h3FF;
    tick();
    bus.start = 1'b0;
    tick();
    check_main("run_3ff", 10'h3FF, 1'b1, 1'b0, 16'd0);
    tick();
    check_main("inc_wrap", 10'h000, 1'b1, 1'b0, 16'd1);
    tick();
    check_main("after_wrap", 10'h001, 1'b1, 1'b0, 16'd2);

    // asynchronous reset between edges
    #3 rst_n = 1'b0;
    #1;
    check_main("async_rst", 10'h000, 1'b0, 1'b0, 16'd0);
    check("async_rst.state", 32'(dbg_state), 32'd0);
    tick();
    check_main("rst_low_edge", 10'h000, 1'b0, 1'b0, 16'd0);
    rst_n = 1'b1;
    tick();
    check_main("post_rst_run", 10'h000, 1'b1, 1'b0, 16'd0);
    tick();
    check_main("post_rst_seq", 10'h001, 1'b1, 1'b0, 16'd1);

    // saturation with a 4-bit counter
    bus_s.start = 1'b0;
    tick();
    check("sat.run", 32'(bus_s.running), 32'd1);
    check("sat.state", 32'(dbg_state_s), 32'd1);
    for (int i = 0; i < 14; i++) tick();
    check("sat.cnt14", 32'(bus_s.inst_cnt), 32'hE);
    tick();
    check("sat.cnt15", 32'(bus_s.inst_cnt), 32'hF);
    for (int i = 0; i < 5; i++) tick();
    check("sat.cnt20", 32'(bus_s.inst_cnt), 32'hF);
    check("sat.pc20", 32'(bus_s.prog_ctr), 32'h014);
    check("sat.ack", 32'(bus_s.ack), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/prog_ctr.md
# prog_ctr

Program-counter and sequencing stage for the single-cycle core. It sits directly downstream of the ALU: it consumes the ALU Zero flag to resolve conditional branches (JEQ-class compare-by-subtract) and drives the instruction-memory address for the next cycle. It also owns the run/halt handshake with the testbench, and keeps a saturating retired-instruction counter.

## Interface
- PW, 10, program-counter width in bits; instruction memory depth is 2^PW.
- OW, 8, width of the signed relative branch offset.
- CW, 16, width of the retired-instruction counter.
- Clk  input  1  clock; all state updates on the rising edge.
- Reset  input  1  asynchronous, active-low reset. Low clears all state immediately, independent of Clk.
- Start  input  1  level request from the testbench; while high, the core is held at StartAddr.
- StartAddr  input  PW  program entry address, sampled while Start is high.
- Halt  input  1  decoded halt instruction in the current cycle.
- Jump  input  1  decoded unconditional relative jump.
- Branch  input  1  decoded conditional branch; taken when Zero=1.
- Zero  input  1  ALU zero flag for the current instruction.
- Offset  input  OW  signed two's-complement relative offset for Jump/Branch.
- ProgCtr  output  PW  current instruction address.
- Running  output  1  high in RUN state.
- Ack  output  1  high in DONE state (program finished).
- InstCnt  output  CW  retired instructions since last Start; saturating.

## Operation
- States: IDLE (reset state), RUN, DONE. Encoding is free; only the outputs are visible.
- Reset low: state=IDLE, ProgCtr=0, InstCnt=0, Running=0, Ack=0.
- Start=1 in any state, highest priority: next state=IDLE, ProgCtr←StartAddr, InstCnt←0.
- IDLE with Start=0: next state=RUN. ProgCtr is unchanged, so the first executed address is StartAddr.
- RUN, with priority Halt > taken-transfer > increment:
  - Halt=1: next state=DONE, ProgCtr unchanged, InstCnt+1.
  - taken = Jump | (Branch & Zero). If taken: ProgCtr←ProgCtr + sign-extended Offset, mod 2^PW.
  - otherwise: ProgCtr←ProgCtr+1, mod 2^PW (PC=2^PW−1 wraps to 0).
  - Every non-Start RUN cycle increments InstCnt. At all-ones, InstCnt holds (no wrap).
- DONE: all state frozen until Start=1. Halt, Jump and Branch are ignored.
- Jump and Branch both high: treated as taken; Zero is irrelevant.
- Branch=1, Zero=0: falls through to PC+1.
- Offset=0 with a taken transfer: PC holds (self-loop); this is legal.
- Jump, Branch and Zero are ignored outside RUN.

## Timing
- Zero arrives combinationally in the same cycle as the instruction at ProgCtr. The branch resolves in that cycle, and the new ProgCtr is visible after the next rising edge. There are no delay slots and no bubbles.
- Running and Ack are registered state decodes: Running=(state==RUN), Ack=(state==DONE). They are glitch-free and change only on a Clk edge or on reset.
- Start-to-first-instruction: Start falls at edge N; IDLE→RUN at edge N+1; instruction at StartAddr executes in cycle N+1.
- Halt seen at edge K: Ack=1 from edge K onward. ProgCtr stays at the halt address.
- Reset asserted mid-RUN: outputs go to reset values immediately (asynchronously). After release, the block stays in IDLE until the first edge with Start=0.
- Start asserted mid-RUN or mid-DONE: restart takes effect at the next edge. The in-flight instruction is not counted.

## Test plan
- Reset/start: Reset low → ProgCtr=0, Ack=0, Running=0. Release Reset, StartAddr=10'h040, Start high 2 cycles then low → Running=1 one edge later, ProgCtr sequence 0x040, 0x041, 0x042.
- Conditional branch: at PC=0x050, Branch=1, Offset=8'hFC (−4). With Zero=1 → next PC=0x04C. Repeat with Zero=0 → next PC=0x051.
- Jump and wrap: at PC=0x3FE, Jump=1, Offset=8'h05 → PC=0x003. With no transfers at PC=0x3FF → PC=0x000.
- Halt/ack: after 7 straight-line instructions, Halt=1 at PC=0x047 → Ack=1, Running=0, ProgCtr holds 0x047 for 20 cycles while Jump toggles, InstCnt=8.
- Restart and async reset: Start high in DONE → Ack=0, InstCnt=0, PC=StartAddr. Then drop Reset between edges mid-RUN → ProgCtr=0 and state IDLE immediately, before the next edge.
- Saturation: CW overridden to 4, run 20 instructions → InstCnt=4'hF and holds.
